// File: rtl/cam_frame_writer.sv
// Write side of the QVGA frame buffer. Resamples the OV7670 byte stream into clk,
// pairs bytes into RGB565 pixels and writes them at y*H_ACTIVE + x.
module cam_frame_writer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_active,
    output logic              frame_done,
    output logic              line_ovf
);
    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_LIMIT   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIMIT   = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic {
        WAIT_FRAME,
        ACTIVE
    } state_t;

    logic [2:0]        pclk_sr;
    logic [2:0]        vsync_sr;
    logic [2:0]        href_sr;
    logic [7:0]        data_s1;
    logic [7:0]        data_s2;
    logic              pclk_rise;
    logic              href_fall;
    logic              vsync_fall;
    logic              vsync_rise;
    state_t            state_q;
    state_t            state_d;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] base;
    logic              phase;
    logic [7:0]        hi;

    // Bit 0 = s1, bit 1 = s2, bit 2 = edge-detect stage. Clearing vsync here keeps
    // a vsync that is already low at reset release from looking like a frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_sr  <= '0;
            vsync_sr <= '0;
            href_sr  <= '0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous
            // cycle's value, so the shift chain stays a true chain of flops.
            pclk_sr  <= {pclk_sr[1:0], cam_pclk};
            vsync_sr <= {vsync_sr[1:0], cam_vsync};
            href_sr  <= {href_sr[1:0], cam_href};
            data_s1  <= cam_data;
            data_s2  <= data_s1;
        end
    end

    assign pclk_rise  =  pclk_sr[1]  & ~pclk_sr[2];
    assign href_fall  = ~href_sr[1]  &  href_sr[2];
    assign vsync_fall = ~vsync_sr[1] &  vsync_sr[2];
    assign vsync_rise =  vsync_sr[1] & ~vsync_sr[2];

    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_FRAME;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vsync_fall) state_d = ACTIVE;
            ACTIVE:     if (vsync_rise) state_d = WAIT_FRAME;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we           <= 1'b0;
            wAddr        <= '0;
            wData        <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            line_ovf     <= 1'b0;
            x            <= '0;
            y            <= '0;
            base         <= '0;
            phase        <= 1'b0;
            hi           <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state_q)
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        x            <= '0;
                        y            <= '0;
                        base         <= '0;
                        phase        <= 1'b0;
                        frame_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // vsync wins over a coincident href fall: that line end is dropped.
                    if (vsync_rise) begin
                        frame_done   <= 1'b1;
                        frame_active <= 1'b0;
                    end else if (href_fall) begin
                        if (x != '0 && y < Y_LIMIT) begin
                            y    <= y + Y_W'(1);
                            base <= base + LINE_STEP;
                        end
                        x     <= '0;
                        phase <= 1'b0;
                    end else if (pclk_rise && href_sr[1]) begin
                        if (!phase) begin
                            hi    <= data_s2;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (x < X_LIMIT && y < Y_LIMIT) begin
                                we    <= 1'b1;
                                wAddr <= base + ADDR_W'(x);
                                wData <= {hi, data_s2};
                            end else if (x >= X_LIMIT) begin
                                line_ovf <= 1'b1;
                            end
                            // x parks at H_ACTIVE so an over-long line cannot wrap back in range.
                            if (x < X_LIMIT) x <= x + X_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer: drives a randomised OV7670 byte stream
// and compares every frame buffer write against a line/pixel reference model.
module tb_cam_frame_writer;
    localparam int H  = 16;
    localparam int V  = 6;
    localparam int AW = 7;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          frame_active;
    logic          frame_done;
    logic          line_ovf;

    int  checks = 0;
    int  errors = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  we_double = 0;
    logic we_prev = 1'b0;

    // Reference model state: frame open, current line index, overflow seen, frames done.
    bit  m_active = 1'b0;
    int  m_y = 0;
    bit  m_ovf = 1'b0;
    int  m_done = 0;

    cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .we(we), .wAddr(wAddr),
        .wData(wData), .frame_active(frame_active), .frame_done(frame_done),
        .line_ovf(line_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) obs_q.push_back({wAddr, wData});
        if (we && we_prev) we_double++;
        we_prev = we;
        if (frame_done) done_cnt++;
    end

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Pixel p of line m_y is bytes 2p/2p+1; it lands at m_y*H+p if inside the frame.
    function automatic void model_line(input bq_t b, input bit line_ends);
        int  npix;
        wr_t w;
        npix = b.size() / 2;
        if (!m_active) return;
        for (int p = 0; p < npix; p++) begin
            if (p < H && m_y < V) begin
                w.addr = AW'(m_y * H + p);
                w.data = {b[2*p], b[2*p+1]};
                exp_q.push_back(w);
            end else if (p >= H) begin
                m_ovf = 1'b1;
            end
        end
        if (line_ends && npix > 0 && m_y < V) m_y++;
    endfunction

    task automatic cam_byte(input logic [7:0] b);
        @(negedge clk);
        cam_data = b;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b0;
    endtask

    task automatic send_line(input bq_t b);
        @(negedge clk);
        cam_href = 1'b1;
        foreach (b[i]) cam_byte(b[i]);
        repeat (2) @(negedge clk);
        cam_href = 1'b0;
        repeat (6) @(negedge clk);
        model_line(b, 1'b1);
    endtask

    task automatic begin_frame();
        @(negedge clk);
        if (!cam_vsync && m_active) begin
            m_done++;
            m_active = 1'b0;
        end
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
        m_active = 1'b1;
        m_y = 0;
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        if (m_active) m_done++;
        m_active = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({we, wAddr, wData, frame_active, frame_done, line_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b wAddr=%0d wData=%h active=%b done=%b ovf=%b, expected all 0",
                     we, wAddr, wData, frame_active, frame_done, line_ovf);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_line();
        bq_t b = '{8'h12, 8'h34, 8'h56, 8'h78};
        begin_frame();
        checks++;
        if (frame_active !== 1'b1) begin
            errors++;
            $display("FAIL basic frame_active_open: got %b expected 1", frame_active);
        end
        send_line(b);
        end_frame();
        checks++;
        if (frame_active !== 1'b0) begin
            errors++;
            $display("FAIL basic frame_active_closed: got %b expected 0", frame_active);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (done_cnt != m_done) begin
            errors++;
            $display("FAIL basic frame_done_count: got %0d expected %0d", done_cnt, m_done);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_frame();
        int d0 = done_cnt;
        begin_frame();
        for (int ly = 0; ly < V; ly++) begin
            bq_t b;
            for (int lx = 0; lx < H; lx++) begin
                logic [15:0] a;
                a = 16'(ly * H + lx);
                b.push_back(a[15:8]);
                b.push_back(a[7:0]);
            end
            send_line(b);
        end
        end_frame();
        checks++;
        if (obs_q.size() != H * V) begin
            errors++;
            $display("FAIL full write_count: got %0d expected %0d", obs_q.size(), H * V);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].data !== 16'(obs_q[i].addr)) begin
                errors++;
                $display("FAIL full write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (wAddr !== AW'(H * V - 1)) begin
            errors++;
            $display("FAIL full last_addr: got %0d expected %0d", wAddr, H * V - 1);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL full frame_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (we_double != 0 || line_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full we_spacing_ovf: got back_to_back=%0d ovf=%b expected 0 and 0", we_double, line_ovf);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_line_overflow();
        begin_frame();
        send_line(rand_bytes(2 * (H + 1)));
        send_line(rand_bytes(6));
        end_frame();
        checks++;
        if (line_ovf !== 1'b1 || !m_ovf) begin
            errors++;
            $display("FAIL ovf flag: got %b expected 1", line_ovf);
        end
        checks++;
        if (obs_q.size() != H + 3) begin
            errors++;
            $display("FAIL ovf write_count: got %0d expected %0d", obs_q.size(), H + 3);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        if (obs_q.size() > H) begin
            checks++;
            if (obs_q[H].addr !== AW'(H)) begin
                errors++;
                $display("FAIL ovf next_line_addr: got %0d expected %0d", obs_q[H].addr, H);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_odd_byte();
        bq_t odd = rand_bytes(5);
        bq_t nxt = rand_bytes(4);
        begin_frame();
        send_line(odd);
        send_line(nxt);
        end_frame();
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL odd write_count: got %0d expected 4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL odd write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_pre_vsync();
        @(negedge clk);
        cam_vsync = 1'b0;
        reset = 1'b1;
        m_active = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (line_ovf !== 1'b0) begin
            errors++;
            $display("FAIL pre_vsync ovf_cleared: got %b expected 0", line_ovf);
        end
        send_line(rand_bytes(8));
        send_line(rand_bytes(6));
        checks++;
        if (obs_q.size() != exp_q.size() || frame_active !== 1'b0) begin
            errors++;
            $display("FAIL pre_vsync no_writes: got %0d writes active=%b expected 0 writes active=0",
                     obs_q.size(), frame_active);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mid_frame_reset();
        bq_t part = rand_bytes(6);
        int  n_pre;
        int  d0;
        begin_frame();
        send_line(rand_bytes(2 * H));
        send_line(rand_bytes(2 * H));
        @(negedge clk);
        cam_href = 1'b1;
        foreach (part[i]) cam_byte(part[i]);
        model_line(part, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        m_active = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({we, wAddr, wData, frame_active, frame_done, line_ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got we=%b wAddr=%0d wData=%h active=%b done=%b ovf=%b, expected all 0",
                     we, wAddr, wData, frame_active, frame_done, line_ovf);
        end
        reset = 1'b0;
        n_pre = obs_q.size();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) cam_byte(8'($urandom));
        repeat (2) @(negedge clk);
        cam_href = 1'b0;
        repeat (6) @(negedge clk);
        send_line(rand_bytes(2 * H));
        end_frame();
        checks++;
        if (obs_q.size() != n_pre || done_cnt != d0) begin
            errors++;
            $display("FAIL mid_reset discard: got %0d writes %0d done expected %0d writes %0d done",
                     obs_q.size() - n_pre, done_cnt - d0, 0, 0);
        end
        begin_frame();
        send_line(rand_bytes(8));
        end_frame();
        if (obs_q.size() > n_pre) begin
            checks++;
            if (obs_q[n_pre].addr !== '0) begin
                errors++;
                $display("FAIL mid_reset first_addr: got %0d expected 0", obs_q[n_pre].addr);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_reset write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_reset write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            int nlines = $urandom_range(0, V + 2);
            begin_frame();
            for (int l = 0; l < nlines; l++) send_line(rand_bytes($urandom_range(0, 2 * (H + 2) + 1)));
            end_frame();
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (line_ovf !== m_ovf) begin
            errors++;
            $display("FAIL random ovf: got %b expected %b", line_ovf, m_ovf);
        end
        checks++;
        if (done_cnt != m_done || we_double != 0) begin
            errors++;
            $display("FAIL random done_spacing: got done=%0d back_to_back=%0d expected done=%0d back_to_back=0",
                     done_cnt, we_double, m_done);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_full_frame();
        test_line_overflow();
        test_odd_byte();
        test_pre_vsync();
        test_mid_frame_reset();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
